// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO-control definitions: arbiter state encoding, legal burst lengths
// and default parameter values.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_e;

  localparam int LEN_MIN = 1;
  localparam int LEN_MAX = 8;

  localparam int NREQ_DEF       = 4;
  localparam int WIDTH_DEF      = 32;
  localparam int DEEPTH_BIT_DEF = 6;
  localparam int DEEPTH_DEF     = 32;
  localparam int LEN_BIT_DEF    = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or after rr_ptr,
// wrapping modulo N; returns a one-hot winner and a valid flag.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     elig,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     win,
  output logic             win_vld
);

  int idx;

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!win_vld && elig[idx]) begin
        win[idx] = 1'b1;
        win_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst write arbiter in front of a FIFO: round-robin grant, beat counting,
// deferred flush. Optional watermark gating under FIFO_WR_ARB_WATERMARK_EN.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEEPTH_BIT = DEEPTH_BIT_DEF,
  parameter int DEEPTH     = DEEPTH_DEF,
  parameter int LEN_BIT    = LEN_BIT_DEF
) (
  input  logic                    wclk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_BIT-1:0] req_len,
  input  logic [NREQ-1:0]         req_vld,
  input  logic [NREQ*WIDTH-1:0]   req_dat,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         beat_rdy,
  input  logic                    flush,
  input  logic [DEEPTH_BIT-1:0]   wlevel,
  input  logic                    full,
`ifdef FIFO_WR_ARB_WATERMARK_EN
  input  logic [DEEPTH_BIT-1:0]   wmark,
  output logic                    almost_full,
`endif
  output logic                    wr_en,
  output logic [WIDTH-1:0]        dati,
  output logic                    wclr,
  output logic                    busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SUM_W = ((DEEPTH_BIT > LEN_BIT) ? DEEPTH_BIT : LEN_BIT) + 2;

  arb_state_e       state, state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] g_idx;
  logic [PTR_W-1:0] win_idx;
  logic [LEN_BIT-1:0] beat_cnt;
  logic             flush_pend;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  win;
  logic             win_vld;
  logic             grant_ok;
  logic             last_beat;

  function automatic logic [LEN_BIT-1:0] len_of(input int i);
    return req_len[i*LEN_BIT +: LEN_BIT];
  endfunction

`ifdef FIFO_WR_ARB_WATERMARK_EN
  always_ff @(posedge wclk) begin
    if (rst) almost_full <= 1'b0;
    else     almost_full <= (wlevel >= wmark);
  end
  assign grant_ok = ~almost_full;
`else
  assign grant_ok = 1'b1;
`endif

  // A burst only starts if the FIFO already has room for every beat of it.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] && grant_ok
             && (len_of(i) >= LEN_BIT'(LEN_MIN))
             && (len_of(i) <= LEN_BIT'(LEN_MAX))
             && ((SUM_W'(wlevel) + SUM_W'(len_of(i))) <= SUM_W'(DEEPTH));
    end
  end

  rr_pick #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .elig    (elig),
    .rr_ptr  (rr_ptr),
    .win     (win),
    .win_vld (win_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  assign last_beat = wr_en && (beat_cnt == LEN_BIT'(1));

  always_ff @(posedge wclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      g_idx      <= '0;
      gnt        <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          flush_pend <= 1'b0;
          if (!(flush || flush_pend) && win_vld) begin
            gnt      <= win;
            g_idx    <= win_idx;
            beat_cnt <= len_of(int'(win_idx));
          end
        end
        ST_BURST: begin
          if (flush)  flush_pend <= 1'b1;
          if (wr_en)  beat_cnt   <= beat_cnt - LEN_BIT'(1);
          if (last_beat) begin
            gnt    <= '0;
            rr_ptr <= (g_idx == PTR_W'(NREQ - 1)) ? '0 : g_idx + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A pending flush always wins over a new grant once the arbiter is idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (flush || flush_pend) state_nxt = ST_FLUSH;
        else if (win_vld)        state_nxt = ST_BURST;
      end
      ST_BURST: if (last_beat) state_nxt = ST_IDLE;
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Reset gates wr_en in its own cycle so an abandoned burst writes nothing more.
  always_comb begin
    wr_en    = 1'b0;
    beat_rdy = '0;
    dati     = req_dat[g_idx*WIDTH +: WIDTH];
    if (state == ST_BURST && !rst) wr_en = req_vld[g_idx] & ~full;
    if (wr_en) beat_rdy = gnt;
    wclr = (state == ST_FLUSH);
    busy = (state != ST_IDLE);
  end

endmodule
